poets_system_multi_timer: RTL



---
 rtl/poets_system_multi_timer_pkg.sv | 32 +++
 rtl/poets_system_multi_timer_if.sv | 23 ++
 rtl/poets_system_multi_timer_channel.sv | 83 ++++++++
 rtl/poets_system_multi_timer.sv | 101 ++++++++++
 4 files changed

// File: rtl/poets_system_multi_timer_pkg.sv
// Shared constants for the multi-channel interval timer: register offsets,
// CONTROL/STATUS bit positions and the page index of the global register page.
// Pure declarations; no logic, no latency, no flow control.
package poets_system_multi_timer_pkg;

  // Channel page register offsets
  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD   = 3'd2;
  localparam logic [2:0] OFF_PRESCALE = 3'd3;
  localparam logic [2:0] OFF_SNAP     = 3'd4;

  // Global page register offsets
  localparam logic [2:0] OFF_PENDING  = 3'd0;
  localparam logic [2:0] OFF_GSTART   = 3'd1;

  // CONTROL bits (START/STOP are write-only strobes)
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // STATUS bits
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // The global page sits directly above the last channel page.
  function automatic int unsigned global_page(input int unsigned num_channels);
    return num_channels;
  endfunction

endpackage

// File: rtl/poets_system_multi_timer_if.sv
// Avalon-MM slave bus bundle of the timer plus its interrupt line.
// Latency: readdata is registered, valid one cycle after a read strobe.
// Backpressure: none; the slave never inserts wait states.
interface poets_system_multi_timer_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] address;     // [ADDR_WIDTH-1:3] page, [2:0] register
  logic                  chipselect;
  logic                  write_n;     // active-low write strobe
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic                  irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/poets_system_multi_timer_channel.sv
// One timer channel: prescaler, down-counter, period/prescale/control regs, TO flag, snapshot.
// Latency: register writes and start strobes take effect on the sampling edge.
// Backpressure: none; every strobe is accepted on the cycle it is presented.
// Ports: clk/reset; decoded write strobes wr_*, global start strobe gstart, wdata;
//        state outputs run, to, cont, ito, period, prescale, snapshot.
module poets_system_multi_timer_channel
  import poets_system_multi_timer_pkg::*;
#(
  parameter int COUNTER_WIDTH  = 32,
  parameter int PRESCALE_WIDTH = 8,
  parameter int RESET_PERIOD   = 49999
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_status,
  input  logic                      wr_control,
  input  logic                      wr_period,
  input  logic                      wr_prescale,
  input  logic                      wr_snap,
  input  logic                      gstart,
  input  logic [31:0]               wdata,
  output logic                      run,
  output logic                      to,
  output logic                      cont,
  output logic                      ito,
  output logic [COUNTER_WIDTH-1:0]  period,
  output logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [COUNTER_WIDTH-1:0]  snapshot
);

  logic [COUNTER_WIDTH-1:0]  counter;
  logic [PRESCALE_WIDTH-1:0] presc_cnt;
  logic load, tick, zero, start, stop, expire;

  // A PERIOD/PRESCALE write reloads the count and overrides any tick that edge.
  assign load   = wr_period | wr_prescale;
  assign tick   = run & (presc_cnt == '0) & ~load;
  assign zero   = (counter == '0);
  assign expire = tick & zero;
  assign start  = (wr_control & wdata[CTRL_START]) | gstart;
  assign stop   = wr_control & wdata[CTRL_STOP];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period    <= COUNTER_WIDTH'(RESET_PERIOD);
      counter   <= COUNTER_WIDTH'(RESET_PERIOD);
      prescale  <= '0;
      presc_cnt <= '0;
      run       <= 1'b0;
      to        <= 1'b0;
      cont      <= 1'b0;
      ito       <= 1'b0;
      snapshot  <= '0;
    end else begin
      if (wr_period)   period   <= wdata[COUNTER_WIDTH-1:0];
      if (wr_prescale) prescale <= wdata[PRESCALE_WIDTH-1:0];
      if (wr_control) begin
        cont <= wdata[CTRL_CONT];
        ito  <= wdata[CTRL_ITO];
      end

      // Captures the value before this edge's decrement/reload.
      if (wr_snap) snapshot <= counter;

      // Timeout set beats a simultaneous STATUS clear.
      if (expire)         to <= 1'b1;
      else if (wr_status) to <= 1'b0;

      if (load) begin
        counter   <= wr_period   ? wdata[COUNTER_WIDTH-1:0]  : period;
        presc_cnt <= wr_prescale ? wdata[PRESCALE_WIDTH-1:0] : prescale;
        run       <= 1'b0;
      end else begin
        if (tick) counter <= zero ? period : counter - COUNTER_WIDTH'(1);
        if (run)  presc_cnt <= tick ? prescale : presc_cnt - PRESCALE_WIDTH'(1);
        // START wins over STOP; STOP or one-shot expiry clear RUN.
        if (start)                        run <= 1'b1;
        else if (stop || (expire && !cont)) run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/poets_system_multi_timer.sv
// Multi-channel interval timer on Avalon-MM: address decode, channel array, read mux, irq.
// Latency: writes act on the sampling edge; readdata is registered, one cycle after the read.
// Backpressure: none; no wait states, every access completes in one cycle.
// Ports: clk, reset (async active-high); bus = Avalon slave (address, chipselect,
//        write_n, writedata, readdata) plus irq = OR of pending channel interrupts.
module poets_system_multi_timer
  import poets_system_multi_timer_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int COUNTER_WIDTH  = 32,
  parameter int PRESCALE_WIDTH = 8,
  parameter int RESET_PERIOD   = 49999,
  parameter int ADDR_WIDTH     = $clog2(NUM_CHANNELS + 1) + 3
) (
  input logic clk,
  input logic reset,
  poets_system_multi_timer_if.slave bus
);

  localparam int PGW = ADDR_WIDTH - 3;
  localparam logic [PGW-1:0] GPAGE = PGW'(global_page(NUM_CHANNELS));

  logic [PGW-1:0] page;
  logic [2:0]     offs;
  logic           wr, rd, wr_gstart;
  logic [31:0]    rd_mux;

  logic [NUM_CHANNELS-1:0]   ch_run, ch_to, ch_cont, ch_ito, pending, gstart;
  logic [COUNTER_WIDTH-1:0]  ch_period   [NUM_CHANNELS];
  logic [PRESCALE_WIDTH-1:0] ch_prescale [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0]  ch_snapshot [NUM_CHANNELS];

  assign page = bus.address[ADDR_WIDTH-1:3];
  assign offs = bus.address[2:0];
  assign wr   = bus.chipselect & ~bus.write_n;
  assign rd   = bus.chipselect &  bus.write_n;

  assign wr_gstart = wr && (page == GPAGE) && (offs == OFF_GSTART);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic wr_ch;
    assign wr_ch     = wr && (page == PGW'(g));
    assign gstart[g] = wr_gstart & bus.writedata[g];

    poets_system_multi_timer_channel #(
      .COUNTER_WIDTH  (COUNTER_WIDTH),
      .PRESCALE_WIDTH (PRESCALE_WIDTH),
      .RESET_PERIOD   (RESET_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .wr_status   (wr_ch && (offs == OFF_STATUS)),
      .wr_control  (wr_ch && (offs == OFF_CONTROL)),
      .wr_period   (wr_ch && (offs == OFF_PERIOD)),
      .wr_prescale (wr_ch && (offs == OFF_PRESCALE)),
      .wr_snap     (wr_ch && (offs == OFF_SNAP)),
      .gstart      (gstart[g]),
      .wdata       (bus.writedata),
      .run         (ch_run[g]),
      .to          (ch_to[g]),
      .cont        (ch_cont[g]),
      .ito         (ch_ito[g]),
      .period      (ch_period[g]),
      .prescale    (ch_prescale[g]),
      .snapshot    (ch_snapshot[g])
    );
  end

  assign pending = ch_to & ch_ito;
  assign bus.irq = |pending;

  // Unmapped pages/offsets fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (page == PGW'(i)) begin
        case (offs)
          OFF_STATUS: begin
            rd_mux[STAT_RUN] = ch_run[i];
            rd_mux[STAT_TO]  = ch_to[i];
          end
          OFF_CONTROL: begin
            rd_mux[CTRL_CONT] = ch_cont[i];
            rd_mux[CTRL_ITO]  = ch_ito[i];
          end
          OFF_PERIOD:   rd_mux = 32'(ch_period[i]);
          OFF_PRESCALE: rd_mux = 32'(ch_prescale[i]);
          OFF_SNAP:     rd_mux = 32'(ch_snapshot[i]);
          default:      rd_mux = '0;
        endcase
      end
    end
    if ((page == GPAGE) && (offs == OFF_PENDING)) rd_mux = 32'(pending);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   bus.readdata <= '0;
    else if (rd) bus.readdata <= rd_mux;
  end

endmodule
